serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial N-bit full adder. It is the additive counterpart of the team's combinational full-subtractor cells and reuses one full-adder slice over WIDTH clock cycles, LSB first. A start/busy/done handshake lets a controller or bench launch an operation and collect sum and carry-out. It sits beside the gate-level adder/subtractor blocks as the area-lean sequential option.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while bits are being processed (SHIFT state)
done  output  1  one-cycle pulse; sum/cout valid from this cycle onward
sum  output  WIDTH  result register, held until next completion
cout  output  1  final carry-out, held until next completion

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; operand shift registers, carry register and bit counter cleared. Takes effect immediately, including mid-operation; the in-flight operation is discarded and no done is produced.
- Reset release: first active edge behaves as normal IDLE.
- States: IDLE, SHIFT, DONE. busy=(state==SHIFT); done=(state==DONE). Both are registered state decodes and carry no combinational path from inputs.
- IDLE: start=1 at edge k loads a, b into shift regs, cin into carry reg, counter=0, and moves to SHIFT. start=0 keeps IDLE.
- SHIFT: each edge computes s=a0^b0^c and c'=(a0&b0)|(c&(a0^b0)) from the current LSBs. s is shifted into the MSB of the working sum register (right shift), the operand regs shift right, carry<=c', and counter increments.
- At the edge that processes bit WIDTH-1 (edge k+WIDTH): copy the completed working sum to sum, final carry to cout, and move to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE. done is therefore high in the cycle after edge k+WIDTH.
- Latency: start accepted at edge k gives done=1 between edges k+WIDTH and k+WIDTH+1.
- Throughput: the earliest next start is accepted at edge k+WIDTH+2, one operation per WIDTH+2 cycles.
- start while in SHIFT or DONE: ignored, with no queuing. Operand changes after capture have no effect.
- sum/cout change only at completion. During an operation they keep showing the previous result.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.

Optional Feature:
Macro OVERFLOW_FLAG_EN.
- Defined: adds output port ovf (1 bit) = signed two's-complement overflow, i.e. carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. It is captured at completion alongside cout, held until the next completion, and reset to 0.
- Not defined: port ovf and its register are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=8, reset then a=0x00, b=0x00, cin=0, start pulse -> busy high 8 cycles, done pulse 8 cycles after start edge, sum=0x00, cout=0 (ovf=0).
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; a=0x3C, b=0x12, cin=0 -> sum=0x4E, cout=0.
3. OVERFLOW_FLAG_EN defined: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1; a=0xFF, b=0x01 -> ovf=0.
4. Start a=0x10, b=0x20, then hold start=1 and change a, b to 0xFF every cycle during SHIFT -> exactly one done, sum=0x30. A second operation is accepted only after returning to IDLE.
5. Assert rst_n=0 for 1 cycle at the 4th SHIFT cycle of a=0xFF, b=0xFF -> busy, done, sum and cout are 0 immediately, no done pulse follows, and a subsequent a=0x01, b=0x02 gives sum=0x03.
6. Back-to-back: start held high continuously with a=0x01, b=0x01 -> done pulses every 10 cycles, sum=0x02 each time, and sum is stable between completions.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder
//
// Bit-serial WIDTH-bit unsigned adder. A single full-adder slice is reused
// over WIDTH clock cycles, LSB first. A start/busy/done handshake launches
// an operation and reports completion. The result registers hold the last
// completed result until the next operation completes.
//
// Optional feature macro: OVERFLOW_FLAG_EN
//   When defined, adds output ovf, the signed two's-complement overflow of
//   the last completed addition.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only while idle
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   cin    in   1      carry-in, captured on accepted start
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle completion pulse
//   sum    out  WIDTH  last completed sum
//   cout   out  1      last completed carry-out
//   ovf    out  1      last completed signed overflow (OVERFLOW_FLAG_EN only)

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef OVERFLOW_FLAG_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [WIDTH-2:0] work;
  logic [CW-1:0]    cnt;

  logic             bit_s;
  logic             bit_c;
  logic             last_bit;

  // One full-adder slice working on the current operand LSBs and the
  // running carry.
  assign bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_c    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Handshake outputs are plain decodes of the state register, so they
  // never depend combinationally on the inputs.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // State register. Reset drops any in-flight operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. start is only looked at while idle; a request seen
  // in SHIFT or DONE is dropped rather than queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Operands are captured once at acceptance and then only
  // shifted, so later changes on a/b/cin cannot disturb the operation.
  // The working register holds the lower WIDTH-1 result bits; on the
  // final bit the new sum bit is joined on top and the whole result,
  // carry and overflow are published together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      work  <= '0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            work  <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= bit_c;
          work  <= (WIDTH-1)'({bit_s, work} >> 1);
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= {bit_s, work};
            cout <= bit_c;
`ifdef OVERFLOW_FLAG_EN
            // carry is the carry into the MSB, bit_c the carry out of it
            ovf  <= carry ^ bit_c;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH=8). A reference model derives
// the expected handshake timing and result from plain arithmetic, and a
// compare process checks every DUT output against it on each falling edge.
// Directed scenarios additionally check hand-computed literal results.
// Define OVERFLOW_FLAG_EN to also exercise the ovf output.

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf;
`endif

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;
  logic cmp_en  = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef OVERFLOW_FLAG_EN
    .cout  (cout),
    .ovf   (ovf)
`else
    .cout  (cout)
`endif
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure distances between done pulses
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: tracks how many edges have passed since the last
  // accepted request and computes the result as ordinary integer addition.
  int               since = -1;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_c;
  logic [WIDTH-1:0] m_sum;
  logic             m_cout;
  logic             m_ovf;
  logic [WIDTH:0]   full_res;
  logic             ovf_res;

  assign full_res = {1'b0, cap_a} + {1'b0, cap_b} + {{WIDTH{1'b0}}, cap_c};
  assign ovf_res  = (cap_a[WIDTH-1] == cap_b[WIDTH-1]) &&
                    (full_res[WIDTH-1] != cap_a[WIDTH-1]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since  <= -1;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (since < 0) begin
      if (start === 1'b1) begin
        since <= 0;
        cap_a <= a;
        cap_b <= b;
        cap_c <= cin;
      end
    end else if (since == WIDTH - 1) begin
      since  <= WIDTH;
      m_sum  <= full_res[WIDTH-1:0];
      m_cout <= full_res[WIDTH];
      m_ovf  <= ovf_res;
    end else if (since == WIDTH) begin
      since <= -1;
    end else begin
      since <= since + 1;
    end
  end

  // Single comparison point: report one line per mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("busy", 32'(busy), 32'(since >= 0 && since < WIDTH));
      checkOutput("done", 32'(done), 32'(since == WIDTH));
      checkOutput("sum",  32'(sum),  32'(m_sum));
      checkOutput("cout", 32'(cout), 32'(m_cout));
`ifdef OVERFLOW_FLAG_EN
      checkOutput("ovf",  32'(ovf),  32'(m_ovf));
`endif
    end
  end

  // Launch one operation from idle, wait for done with a cycle bound and
  // check latency, busy length and the literal result.
  task automatic applyStimulus(input string name, input logic [7:0] va,
                               input logic [7:0] vb, input logic vc,
                               input logic [7:0] exp_sum, input logic exp_cout,
                               input logic exp_ovf);
    int n;
    int busy_cnt;
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 30) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    checkOutput({name, " done_seen"}, 32'(done), 32'd1);
    checkOutput({name, " latency"}, 32'(n - 1), 32'(WIDTH));
    checkOutput({name, " busy_len"}, 32'(busy_cnt), 32'(WIDTH));
    checkOutput({name, " sum"}, 32'(sum), 32'(exp_sum));
    checkOutput({name, " cout"}, 32'(cout), 32'(exp_cout));
`ifdef OVERFLOW_FLAG_EN
    checkOutput({name, " ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("[TB] unexpected ovf literal");
`endif
    @(negedge clk);
  endtask

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dones;
    int prev;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sum",  32'(sum),  32'd0);
    checkOutput("reset cout", 32'(cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Basic additions, including carry-out and carry-in cases
    applyStimulus("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("a5+5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    applyStimulus("3c+12", 8'h3C, 8'h12, 1'b0, 8'h4E, 1'b0, 1'b0);
    // Signed overflow boundaries
    applyStimulus("7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    applyStimulus("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus("7f+00c",8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

    // Start held high with operands changing while busy: one result only
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    dones = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        checkOutput("hold sum", 32'(sum), 32'h30);
        @(negedge clk);
        break;
      end
      a = 8'hFF; b = 8'hFF;
    end
    start = 1'b0;
    checkOutput("hold dones", 32'(dones), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checkOutput("hold no_extra", 32'(dones), 32'd1);

    // Reset in the fourth SHIFT cycle of FF+FF
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst done", 32'(done), 32'd0);
    checkOutput("midrst sum",  32'(sum),  32'd0);
    checkOutput("midrst cout", 32'(cout), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checkOutput("midrst no_done", 32'(dones), 32'd0);
    applyStimulus("01+02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Back-to-back with start held high continuously
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    dones = 0;
    prev = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        checkOutput("b2b sum", 32'(sum), 32'h02);
        if (prev >= 0) checkOutput("b2b period", 32'(cyc - prev), 32'd10);
        prev = cyc;
      end
    end
    start = 1'b0;
    checkOutput("b2b count", 32'(dones), 32'd4);
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
